reg_wb_stage: RTL and testbench

- Write-back stage that feeds the single write port of the CPU's 32x32 register file.
- Accepts one retiring instruction at a time from the execute/memory stage.
- For loads, waits on a valid/ready memory read-data handshake, then extracts and sign- or zero-extends the addressed byte, halfword or word.
- Drives a one-cycle register-file write strobe with destination and data, and keeps a count of retired write-backs.

---
 rtl/reg_wb_stage.sv | 176 +++++++++++++++++
 tb/tb_reg_wb_stage.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_wb_stage.sv
// -----------------------------------------------------------------------------
// reg_wb_stage
//
// Write-back stage for the CPU's 32x32 register file. It accepts one retiring
// instruction at a time. ALU results go straight to a one-cycle write. Loads
// first wait for a memory read-data beat. The addressed byte, halfword or word
// is then extracted and sign- or zero-extended, and the write follows. A
// free-running counter records every completed write-back, including writes
// to r0 that are suppressed at the register file.
//
// Ports:
//   clk, resetn          clock (rising edge) / asynchronous active-low reset
//   in_valid/in_ready    retiring-instruction handshake
//   in_is_load           result comes from memory rather than in_alu_result
//   in_rd                destination register index
//   in_alu_result        result for non-load instructions
//   in_load_type         000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu (else lw)
//   in_byte_off          low two bits of the load address
//   mem_rdata_valid/ready, mem_rdata   aligned memory read-data handshake
//   rf_wen, rf_waddr, rf_wdata         register-file write port
//   wb_count             number of completed write-backs (wraps)
// -----------------------------------------------------------------------------
module reg_wb_stage #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  in_is_load,
    input  logic [ADDR_WIDTH-1:0] in_rd,
    input  logic [DATA_WIDTH-1:0] in_alu_result,
    input  logic [2:0]            in_load_type,
    input  logic [1:0]            in_byte_off,
    input  logic                  mem_rdata_valid,
    output logic                  mem_rdata_ready,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  rf_wen,
    output logic [ADDR_WIDTH-1:0] rf_waddr,
    output logic [DATA_WIDTH-1:0] rf_wdata,
    output logic [31:0]           wb_count
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_MEM = 2'd1,
        WRITE    = 2'd2
    } state_e;

    localparam logic [2:0] LT_LB  = 3'b000;
    localparam logic [2:0] LT_LH  = 3'b001;
    localparam logic [2:0] LT_LBU = 3'b100;
    localparam logic [2:0] LT_LHU = 3'b101;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] rd_q, rd_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [2:0]            load_type_q, load_type_d;
    logic [1:0]            off_q, off_d;
    logic [31:0]           wb_count_q, wb_count_d;

    logic in_xfer;
    logic mem_xfer;

    // Byte/halfword extraction from an aligned word. The halfword is picked by
    // off[1] alone, so a misaligned lh/lhu still reads a naturally aligned half.
    // Codes that are not lb/lh/lbu/lhu fall through to lw and ignore the offset.
    function automatic logic [DATA_WIDTH-1:0] extract(
        input logic [DATA_WIDTH-1:0] word,
        input logic [2:0]            load_type,
        input logic [1:0]            off
    );
        logic [7:0]  byte_sel;
        logic [15:0] half_sel;
        byte_sel = 8'(word >> {off, 3'b000});
        half_sel = 16'(word >> {off[1], 4'b0000});
        case (load_type)
            LT_LB:   extract = {{(DATA_WIDTH-8){byte_sel[7]}}, byte_sel};
            LT_LBU:  extract = {{(DATA_WIDTH-8){1'b0}}, byte_sel};
            LT_LH:   extract = {{(DATA_WIDTH-16){half_sel[15]}}, half_sel};
            LT_LHU:  extract = {{(DATA_WIDTH-16){1'b0}}, half_sel};
            default: extract = word;
        endcase
    endfunction

    assign in_xfer  = in_valid && in_ready;
    assign mem_xfer = mem_rdata_valid && mem_rdata_ready;

    // -------------------------------------------------------------------------
    // State and datapath registers
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge values, independent of process evaluation order.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= IDLE;
            rd_q        <= '0;
            wdata_q     <= '0;
            load_type_q <= '0;
            off_q       <= '0;
            wb_count_q  <= '0;
        end else begin
            state_q     <= state_d;
            rd_q        <= rd_d;
            wdata_q     <= wdata_d;
            load_type_q <= load_type_d;
            off_q       <= off_d;
            wb_count_q  <= wb_count_d;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    // NOTE: every combinational output gets a default before the case, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (in_xfer) state_d = in_is_load ? WAIT_MEM : WRITE;
            end
            WAIT_MEM: begin
                if (mem_xfer) state_d = WRITE;
            end
            WRITE: begin
                // The write in flight always completes. A new instruction
                // accepted in the same cycle chains directly to its next state.
                if (in_xfer) state_d = in_is_load ? WAIT_MEM : WRITE;
                else         state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // Datapath next values
    // -------------------------------------------------------------------------
    always_comb begin
        rd_d        = rd_q;
        wdata_d     = wdata_q;
        load_type_d = load_type_q;
        off_d       = off_q;
        wb_count_d  = wb_count_q;

        // in_xfer and mem_xfer cannot both be true, because in_ready and
        // mem_rdata_ready are asserted in disjoint states.
        if (in_xfer) begin
            rd_d        = in_rd;
            load_type_d = in_load_type;
            off_d       = in_byte_off;
            if (!in_is_load) wdata_d = in_alu_result;
        end

        if (mem_xfer) wdata_d = extract(mem_rdata, load_type_q, off_q);

        if (state_q == WRITE) wb_count_d = wb_count_q + 32'd1;
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    always_comb begin
        in_ready        = (state_q == IDLE) || (state_q == WRITE);
        mem_rdata_ready = (state_q == WAIT_MEM);
        // A write to r0 still counts as a write-back, but no write strobe is
        // raised for it.
        rf_wen          = (state_q == WRITE) && (rd_q != '0);
    end

    assign rf_waddr = rd_q;
    assign rf_wdata = wdata_q;
    assign wb_count = wb_count_q;

endmodule

// File: tb/tb_reg_wb_stage.sv
// -----------------------------------------------------------------------------
// tb_reg_wb_stage
//
// Directed self-checking bench for reg_wb_stage. A table of load-extraction
// vectors is run in a loop. Hand-written sequences cover reset, ALU
// write-backs, back-to-back issue, a load chained behind a write, a delayed
// memory beat and reset in the middle of a load. Inputs change on the falling
// edge, and outputs are sampled on the falling edge before new inputs are
// applied.
// -----------------------------------------------------------------------------
module tb_reg_wb_stage;

    localparam int DW = 32;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          resetn;
    logic          in_valid;
    logic          in_ready;
    logic          in_is_load;
    logic [AW-1:0] in_rd;
    logic [DW-1:0] in_alu_result;
    logic [2:0]    in_load_type;
    logic [1:0]    in_byte_off;
    logic          mem_rdata_valid;
    logic          mem_rdata_ready;
    logic [DW-1:0] mem_rdata;
    logic          rf_wen;
    logic [AW-1:0] rf_waddr;
    logic [DW-1:0] rf_wdata;
    logic [31:0]   wb_count;

    int n_cmp  = 0;
    int n_fail = 0;
    logic [31:0] exp_count;

    reg_wb_stage #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk             (clk),
        .resetn          (resetn),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .in_is_load      (in_is_load),
        .in_rd           (in_rd),
        .in_alu_result   (in_alu_result),
        .in_load_type    (in_load_type),
        .in_byte_off     (in_byte_off),
        .mem_rdata_valid (mem_rdata_valid),
        .mem_rdata_ready (mem_rdata_ready),
        .mem_rdata       (mem_rdata),
        .rf_wen          (rf_wen),
        .rf_waddr        (rf_waddr),
        .rf_wdata        (rf_wdata),
        .wb_count        (wb_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [2:0]  load_type;
        logic [1:0]  off;
        logic [31:0] rdata;
        logic [31:0] exp_data;
    } vec_t;

    vec_t vecs[14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        in_valid        = 1'b0;
        in_is_load      = 1'b0;
        in_rd           = '0;
        in_alu_result   = '0;
        in_load_type    = '0;
        in_byte_off     = '0;
        mem_rdata_valid = 1'b0;
        mem_rdata       = '0;
    endtask

    task automatic drive_alu(input logic [AW-1:0] rd, input logic [31:0] val);
        in_valid      = 1'b1;
        in_is_load    = 1'b0;
        in_rd         = rd;
        in_alu_result = val;
    endtask

    task automatic drive_load(input logic [AW-1:0] rd, input logic [2:0] lt, input logic [1:0] off);
        in_valid      = 1'b1;
        in_is_load    = 1'b1;
        in_rd         = rd;
        in_load_type  = lt;
        in_byte_off   = off;
        in_alu_result = 32'hDEAD_BEEF;
    endtask

    initial begin
        // Extraction vectors; expected values are worked out by hand from the
        // word, the byte offset and the load type.
        vecs[0]  = '{"lb_off3",   3'b000, 2'd3, 32'h80FF7F01, 32'hFFFFFF80};
        vecs[1]  = '{"lbu_off3",  3'b100, 2'd3, 32'h80FF7F01, 32'h00000080};
        vecs[2]  = '{"lh_off2",   3'b001, 2'd2, 32'h80FF7F01, 32'hFFFF80FF};
        vecs[3]  = '{"lhu_off0",  3'b101, 2'd0, 32'h80FF7F01, 32'h00007F01};
        vecs[4]  = '{"lw_off1",   3'b010, 2'd1, 32'h80FF7F01, 32'h80FF7F01};
        vecs[5]  = '{"lb_off0",   3'b000, 2'd0, 32'h80FF7F01, 32'h00000001};
        vecs[6]  = '{"lb_off1",   3'b000, 2'd1, 32'h80FF7F01, 32'h0000007F};
        vecs[7]  = '{"lb_off2",   3'b000, 2'd2, 32'h80FF7F01, 32'hFFFFFFFF};
        vecs[8]  = '{"lh_off3",   3'b001, 2'd3, 32'h80FF7F01, 32'hFFFF80FF};
        vecs[9]  = '{"lh_off1",   3'b001, 2'd1, 32'h80FF7F01, 32'h00007F01};
        vecs[10] = '{"lhu_off2",  3'b101, 2'd2, 32'h80FF7F01, 32'h000080FF};
        vecs[11] = '{"lhu_off1",  3'b101, 2'd1, 32'hC3A5_1234, 32'h00001234};
        vecs[12] = '{"lt011_off2",3'b011, 2'd2, 32'h80FF7F01, 32'h80FF7F01};
        vecs[13] = '{"lt111_off3",3'b111, 2'd3, 32'h1234_5678, 32'h12345678};

        idle_inputs();
        resetn    = 1'b0;
        exp_count = '0;

        // ---------------- 1. reset then idle ----------------
        repeat (3) @(negedge clk);
        check("rst_rf_wen", {31'b0, rf_wen}, 32'd0);
        check("rst_mem_ready", {31'b0, mem_rdata_ready}, 32'd0);
        resetn = 1'b1;
        @(negedge clk);
        check("idle_rf_wen", {31'b0, rf_wen}, 32'd0);
        check("idle_in_ready", {31'b0, in_ready}, 32'd1);
        check("idle_mem_ready", {31'b0, mem_rdata_ready}, 32'd0);
        check("idle_wb_count", wb_count, 32'd0);
        check("idle_waddr", {27'b0, rf_waddr}, 32'd0);
        check("idle_wdata", rf_wdata, 32'd0);

        // ---------------- 2. single ALU instruction ----------------
        drive_alu(5'd5, 32'h12345678);
        @(negedge clk);
        in_valid = 1'b0;
        check("alu_wen", {31'b0, rf_wen}, 32'd1);
        check("alu_waddr", {27'b0, rf_waddr}, 32'd5);
        check("alu_wdata", rf_wdata, 32'h12345678);
        exp_count++;
        @(negedge clk);
        check("alu_count", wb_count, exp_count);
        check("alu_wen_drop", {31'b0, rf_wen}, 32'd0);
        check("alu_waddr_hold", {27'b0, rf_waddr}, 32'd5);

        // ---------------- 3. back-to-back ALU ----------------
        check("b2b_ready0", {31'b0, in_ready}, 32'd1);
        drive_alu(5'd1, 32'h0000000A);
        @(negedge clk);
        check("b2b_ready1", {31'b0, in_ready}, 32'd1);
        check("b2b_wen1", {31'b0, rf_wen}, 32'd1);
        check("b2b_waddr1", {27'b0, rf_waddr}, 32'd1);
        check("b2b_wdata1", rf_wdata, 32'h0000000A);
        exp_count++;
        drive_alu(5'd2, 32'h0000000B);
        @(negedge clk);
        check("b2b_ready2", {31'b0, in_ready}, 32'd1);
        check("b2b_wen2", {31'b0, rf_wen}, 32'd1);
        check("b2b_waddr2", {27'b0, rf_waddr}, 32'd2);
        check("b2b_wdata2", rf_wdata, 32'h0000000B);
        exp_count++;
        drive_alu(5'd0, 32'h0000000C);
        @(negedge clk);
        in_valid = 1'b0;
        check("b2b_wen_r0", {31'b0, rf_wen}, 32'd0);
        check("b2b_wdata_r0", rf_wdata, 32'h0000000C);
        check("b2b_count_mid", wb_count, exp_count);
        exp_count++;
        @(negedge clk);
        check("b2b_count", wb_count, exp_count);

        // ---------------- load accepted during a WRITE ----------------
        drive_alu(5'd3, 32'h00000033);
        @(negedge clk);
        drive_load(5'd4, 3'b010, 2'd0);
        check("chain_wen", {31'b0, rf_wen}, 32'd1);
        check("chain_waddr", {27'b0, rf_waddr}, 32'd3);
        check("chain_wdata", rf_wdata, 32'h00000033);
        exp_count++;
        @(negedge clk);
        in_valid = 1'b0;
        check("chain_mem_ready", {31'b0, mem_rdata_ready}, 32'd1);
        check("chain_wen_wait", {31'b0, rf_wen}, 32'd0);
        mem_rdata_valid = 1'b1;
        mem_rdata       = 32'hCAFE_F00D;
        @(negedge clk);
        mem_rdata_valid = 1'b0;
        check("chain_ld_wen", {31'b0, rf_wen}, 32'd1);
        check("chain_ld_waddr", {27'b0, rf_waddr}, 32'd4);
        check("chain_ld_wdata", rf_wdata, 32'hCAFE_F00D);
        exp_count++;
        @(negedge clk);

        // ---------------- 4. load extraction table ----------------
        for (int i = 0; i < 14; i++) begin
            drive_load(5'd7, vecs[i].load_type, vecs[i].off);
            @(negedge clk);
            in_valid = 1'b0;
            check({vecs[i].name, "_mem_ready"}, {31'b0, mem_rdata_ready}, 32'd1);
            check({vecs[i].name, "_in_ready"}, {31'b0, in_ready}, 32'd0);
            mem_rdata_valid = 1'b1;
            mem_rdata       = vecs[i].rdata;
            @(negedge clk);
            mem_rdata_valid = 1'b0;
            check({vecs[i].name, "_wen"}, {31'b0, rf_wen}, 32'd1);
            check({vecs[i].name, "_waddr"}, {27'b0, rf_waddr}, 32'd7);
            check({vecs[i].name, "_wdata"}, rf_wdata, vecs[i].exp_data);
            check({vecs[i].name, "_count"}, wb_count, exp_count);
            exp_count++;
            @(negedge clk);
        end
        check("tbl_count", wb_count, exp_count);

        // ---------------- 5. delayed memory data ----------------
        drive_load(5'd9, 3'b100, 2'd1);
        @(negedge clk);
        // A competing ALU instruction is offered while the stage is busy. It
        // must not be taken.
        drive_alu(5'd12, 32'h5555_5555);
        for (int c = 0; c < 4; c++) begin
            check("dly_in_ready", {31'b0, in_ready}, 32'd0);
            check("dly_mem_ready", {31'b0, mem_rdata_ready}, 32'd1);
            check("dly_wen", {31'b0, rf_wen}, 32'd0);
            check("dly_waddr", {27'b0, rf_waddr}, 32'd9);
            @(negedge clk);
        end
        in_valid        = 1'b0;
        check("dly_mem_ready5", {31'b0, mem_rdata_ready}, 32'd1);
        mem_rdata_valid = 1'b1;
        mem_rdata       = 32'h0000_AB00;
        @(negedge clk);
        mem_rdata_valid = 1'b0;
        check("dly_wen6", {31'b0, rf_wen}, 32'd1);
        check("dly_waddr6", {27'b0, rf_waddr}, 32'd9);
        check("dly_wdata6", rf_wdata, 32'h0000_00AB);
        exp_count++;
        @(negedge clk);
        check("dly_count", wb_count, exp_count);
        check("dly_idle_wen", {31'b0, rf_wen}, 32'd0);

        // ---------------- 6. reset in the middle of a load ----------------
        drive_load(5'd6, 3'b010, 2'd0);
        @(negedge clk);
        in_valid = 1'b0;
        check("mrst_wait", {31'b0, mem_rdata_ready}, 32'd1);
        #2;
        resetn = 1'b0;
        #1;
        exp_count = '0;
        check("mrst_mem_ready", {31'b0, mem_rdata_ready}, 32'd0);
        check("mrst_in_ready", {31'b0, in_ready}, 32'd1);
        check("mrst_wen", {31'b0, rf_wen}, 32'd0);
        check("mrst_count", wb_count, exp_count);
        check("mrst_waddr", {27'b0, rf_waddr}, 32'd0);
        // The memory beat now arrives while the stage is in reset and then IDLE.
        // It must never be taken.
        mem_rdata_valid = 1'b1;
        mem_rdata       = 32'h7777_7777;
        repeat (2) begin
            @(negedge clk);
            check("mrst_hold_wen", {31'b0, rf_wen}, 32'd0);
        end
        resetn = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("mrst_post_wen", {31'b0, rf_wen}, 32'd0);
            check("mrst_post_mem_ready", {31'b0, mem_rdata_ready}, 32'd0);
            check("mrst_post_count", wb_count, exp_count);
        end
        mem_rdata_valid = 1'b0;
        check("mrst_wdata", rf_wdata, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
